spi_cfg_master: RTL and testbench
=================================

Name: spi_cfg_master

Overview:
- SPI master (mode 0, CPOL=0/CPHA=0) that drives the chip's 4-wire SPI configuration port from the host/test side.
- Converts a one-word register request (R/W, 7-bit address, 8-bit data) into one 16-bit SPI frame, returns read data, and enforces CS setup, hold and gap timing.
- Sits in the bring-up/test controller and is the initiator for the chip's SPI responder.

Parameters:
- CLK_DIV, 4, clk_osc cycles per SPI_CLK half-period; must be >= 3, elaboration error otherwise.
- ADDR_W, 7, register address width.
- DATA_W, 8, register data width; frame length FRAME_W = 1 + ADDR_W + DATA_W (16 by default).

Ports:
- clk_osc  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master idle and can accept a request.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  register address.
- req_wdata  in  DATA_W  write data; ignored on reads.
- rsp_valid  out  1  one-cycle pulse at frame end.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- busy  out  1  high from accept until the end of GAP.
- SPI_CS  out  1  chip select, active low.
- SPI_CLK  out  1  serial clock, idle low.
- SPI_MOSI  out  1  serial data to the responder.
- SPI_MISO  in  1  serial data from the responder; asynchronous, passes through a 2-flop synchronizer.

Behaviour:
- Reset values: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, FSM=IDLE. A reset during a frame aborts it immediately; no rsp_valid is issued.
- All SPI outputs are driven from flops, with no combinational path to the pins.
- Frame: {rw, addr, wdata_or_zero}, MSB first. Reads send zeros in the data field.
- FSM states: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: req_ready=1. On req_valid && req_ready at cycle T, latch the frame into a shift register and go to SHIFT. Later changes on the request inputs are ignored.
- SHIFT, cycles T+1 onward:
  - SPI_CS=0. Each bit is CLK_DIV cycles with SPI_CLK low, then CLK_DIV cycles with SPI_CLK high.
  - SPI_MOSI updates on the first cycle of each low half. The low half of bit 15 provides CS-to-clock setup.
  - Read sampling: on the last clk_osc cycle of each high half, the synchronized MISO shifts into the receive register LSB first-in, giving MSB-first order.
  - The half-period counter runs 0..CLK_DIV-1; the bit counter runs FRAME_W-1 down to 0.
- HOLD: after the final high half, SPI_CLK=0 and SPI_CS=0 for CLK_DIV cycles.
- GAP:
  - SPI_CS=1 and SPI_MOSI=0 for CLK_DIV cycles.
  - rsp_valid pulses on the first GAP cycle. rsp_rdata = last DATA_W received bits for a read, 0 for a write, and holds until the next rsp_valid.
  - Then go to IDLE.
- Timing from accept cycle T: CS falls at T+1; first SPI_CLK rise at T+CLK_DIV+1; CS rises and rsp_valid at T+33*CLK_DIV+1; req_ready=1 at T+34*CLK_DIV+1. With CLK_DIV=4 these are T+133 and T+137.
- busy = !req_ready.
- Back-to-back requests: a held req_valid is accepted in the first IDLE cycle. The minimum CS-high time is CLK_DIV+1 cycles.
- MISO is sampled about 2 cycles after entering the synchronizer, so its effective sample point lies inside the high half. This is why CLK_DIV >= 3.

Decomposition:
- Package spi_cfg_pkg:
  - state enum {IDLE, SHIFT, HOLD, GAP};
  - RW_READ=1 and RW_WRITE=0 constants;
  - FRAME_W function of ADDR_W/DATA_W.
- Sub-module sync2: a 2-flop synchronizer with async active-low reset to 0, used for SPI_MISO.

Test Plan:
- Write addr=0x15, data=0xA5, CLK_DIV=4 -> MOSI bits over 16 SPI_CLK rises = 0_0010101_10100101; CS low T+1..T+132; rsp_valid at T+133 with rdata=0x00.
- Read addr=0x7F; responder model drives 0x3C on MISO bits 7..0 (changing on SPI_CLK fall) -> MOSI = 1_1111111_00000000; rsp_rdata=0x3C at T+133.
- req_valid held for a write then a read -> second CS fall exactly CLK_DIV+1 cycles after first CS rise; req_ready low for the whole of each frame.
- rst_n asserted at T+50 of a frame -> same cycle CS=1, SPI_CLK=0, MOSI=0; no rsp_valid; after release, a new request completes normally.
- CLK_DIV=3, read of 0xFF then 0x00 -> both returned exactly; SPI_CLK period 6 cycles, frame ends T+100.
- Request inputs changed on cycle T+1 -> transmitted frame still matches the values latched at T.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared types and helpers for the SPI configuration master.
package spi_cfg_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset to 0.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/spi_cfg_master.sv
// Mode-0 SPI master: one register request becomes one {rw, addr, data} frame, MSB first,
// with CS setup/hold/gap timing and read data returned on rsp_valid.
module spi_cfg_master #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned ADDR_W  = 7,
   parameter int unsigned DATA_W  = 8
) (
   input  logic              clk_osc,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              SPI_CS,
   output logic              SPI_CLK,
   output logic              SPI_MOSI,
   input  logic              SPI_MISO
);
   import spi_cfg_pkg::*;

   localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int unsigned HC_W    = $clog2(CLK_DIV);
   localparam int unsigned BC_W    = $clog2(FRAME_W);
   localparam logic [HC_W-1:0] HC_LAST  = HC_W'(CLK_DIV - 1);
   localparam logic [BC_W-1:0] BC_FIRST = BC_W'(FRAME_W - 1);

   // The synchronizer delays MISO by two cycles; the sample must still land in the high half.
   if (CLK_DIV < 3) begin : g_clk_div_check
      $error("spi_cfg_master: CLK_DIV must be >= 3");
   end

   state_e              state_q, state_d;
   logic [HC_W-1:0]     hcnt_q, hcnt_d;
   logic [BC_W-1:0]     bcnt_q, bcnt_d;
   logic [FRAME_W-1:0]  shreg_q, shreg_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rw_q, rw_d;
   logic                cs_q, cs_d;
   logic                sclk_q, sclk_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                miso_s;
   logic                hc_done;

   sync2 u_miso_sync (
      .clk   (clk_osc),
      .rst_n (rst_n),
      .d     (SPI_MISO),
      .q     (miso_s)
   );

   assign hc_done = (hcnt_q == HC_LAST);

   always_comb begin
      state_d     = state_q;
      hcnt_d      = hcnt_q;
      bcnt_d      = bcnt_q;
      shreg_d     = shreg_q;
      rx_d        = rx_q;
      rdata_d     = rdata_q;
      rw_d        = rw_q;
      cs_d        = cs_q;
      sclk_d      = sclk_q;
      rsp_valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = SHIFT;
               cs_d    = 1'b0;
               sclk_d  = 1'b0;
               hcnt_d  = '0;
               bcnt_d  = BC_FIRST;
               rw_d    = req_rw;
               shreg_d = {req_rw, req_addr,
                          (req_rw == RW_READ) ? {DATA_W{1'b0}} : req_wdata};
            end
         end
         SHIFT: begin
            hcnt_d = hcnt_q + HC_W'(1);
            if (hc_done) begin
               hcnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // End of the high half: capture MISO and present the next MOSI bit.
                  sclk_d  = 1'b0;
                  rx_d    = {rx_q[DATA_W-2:0], miso_s};
                  shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                  if (bcnt_q == '0) begin
                     state_d = HOLD;
                  end else begin
                     bcnt_d = bcnt_q - BC_W'(1);
                  end
               end
            end
         end
         HOLD: begin
            hcnt_d = hcnt_q + HC_W'(1);
            if (hc_done) begin
               state_d     = GAP;
               hcnt_d      = '0;
               cs_d        = 1'b1;
               rsp_valid_d = 1'b1;
               rdata_d     = (rw_q == RW_READ) ? rx_q : {DATA_W{1'b0}};
            end
         end
         GAP: begin
            hcnt_d = hcnt_q + HC_W'(1);
            if (hc_done) begin
               state_d = IDLE;
               hcnt_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_osc or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hcnt_q      <= '0;
         bcnt_q      <= '0;
         shreg_q     <= '0;
         rx_q        <= '0;
         rdata_q     <= '0;
         rw_q        <= RW_WRITE;
         cs_q        <= 1'b1;
         sclk_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         bcnt_q      <= bcnt_d;
         shreg_q     <= shreg_d;
         rx_q        <= rx_d;
         rdata_q     <= rdata_d;
         rw_q        <= rw_d;
         cs_q        <= cs_d;
         sclk_q      <= sclk_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // The shift register drains to zero by the end of the frame, so MOSI idles low.
   assign SPI_MOSI  = shreg_q[FRAME_W-1];
   assign SPI_CS    = cs_q;
   assign SPI_CLK   = sclk_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign req_ready = (state_q == IDLE);
   assign busy      = !req_ready;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: CLK_DIV=4 and CLK_DIV=3 instances, a MISO responder model,
// and a scoreboard of expected frames/read data checked at each rsp_valid.
module tb_spi_cfg_master;

   typedef struct {
      logic [15:0] frame;
      logic [7:0]  miso;
      logic [7:0]  rdata;
   } exp_t;

   typedef struct {
      int          d;
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  miso;
      logic [7:0]  rdata;
   } vec_t;

   logic clk_osc = 1'b0;
   logic rst_n   = 1'b0;
   always #5 clk_osc = ~clk_osc;

   logic       req_valid[2], req_ready[2], req_rw[2], rsp_valid[2], busy[2];
   logic       spi_cs[2], spi_clk[2], spi_mosi[2], spi_miso[2];
   logic [6:0] req_addr[2];
   logic [7:0] req_wdata[2], rsp_rdata[2];

   spi_cfg_master #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8)) u_dut4 (
      .clk_osc(clk_osc), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
      .SPI_CS(spi_cs[0]), .SPI_CLK(spi_clk[0]), .SPI_MOSI(spi_mosi[0]), .SPI_MISO(spi_miso[0])
   );

   spi_cfg_master #(.CLK_DIV(3), .ADDR_W(7), .DATA_W(8)) u_dut3 (
      .clk_osc(clk_osc), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
      .SPI_CS(spi_cs[1]), .SPI_CLK(spi_clk[1]), .SPI_MOSI(spi_mosi[1]), .SPI_MISO(spi_miso[1])
   );

   int unsigned cyc = 0;
   always @(posedge clk_osc) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t q0[$];
   exp_t q1[$];

   // Monitor / responder state, per instance.
   int unsigned accept_cyc[2], cs_fall_cyc[2], cs_rise_cyc[2], rise0_cyc[2], rsp_cyc[2];
   int unsigned gap_cyc[2];
   int          nrise[2], resp_idx[2];
   logic [15:0] cap[2], resp_frame[2];
   logic        prev_cs[2], prev_clk[2], prev_ready[2], prev_rsp[2];
   logic        ready_in_frame[2], ready_pending[2];
   exp_t        mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int unsigned cdiv(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic void push_exp(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   function automatic exp_t pop_exp(input int d);
      if (d == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   function automatic logic [7:0] head_miso(input int d);
      if (qsize(d) == 0) return 8'h00;
      return (d == 0) ? q0[0].miso : q1[0].miso;
   endfunction

   always @(negedge clk_osc) begin
      for (int d = 0; d < 2; d++) begin
         if (req_valid[d] && req_ready[d]) begin
            accept_cyc[d]     = cyc;
            nrise[d]          = 0;
            cap[d]            = '0;
            ready_in_frame[d] = 1'b0;
         end
         if (!spi_cs[d] && req_ready[d]) ready_in_frame[d] = 1'b1;
         // Responder: first bit at CS fall, then a new bit on each SPI_CLK fall.
         if (prev_cs[d] && !spi_cs[d]) begin
            cs_fall_cyc[d] = cyc;
            gap_cyc[d]     = cyc - cs_rise_cyc[d];
            resp_frame[d]  = {8'h00, head_miso(d)};
            resp_idx[d]    = 15;
            spi_miso[d]    = resp_frame[d][15];
         end else if (!spi_cs[d] && prev_clk[d] && !spi_clk[d] && resp_idx[d] > 0) begin
            resp_idx[d] = resp_idx[d] - 1;
            spi_miso[d] = resp_frame[d][resp_idx[d]];
         end
         if (!prev_cs[d] && spi_cs[d]) cs_rise_cyc[d] = cyc;
         if (!prev_clk[d] && spi_clk[d]) begin
            if (nrise[d] == 0) begin
               rise0_cyc[d] = cyc;
               check("first_sclk_rise", cyc, accept_cyc[d] + cdiv(d) + 1);
            end
            if (nrise[d] == 1) check("sclk_period", cyc - rise0_cyc[d], 2 * cdiv(d));
            cap[d]   = {cap[d][14:0], spi_mosi[d]};
            nrise[d] = nrise[d] + 1;
         end
         if (rsp_valid[d]) begin
            if (qsize(d) == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               mon_e = pop_exp(d);
               check("rsp_rdata", rsp_rdata[d], mon_e.rdata);
               check("mosi_frame", cap[d], mon_e.frame);
               check("sclk_rises", nrise[d], 16);
               check("rsp_cycle", cyc, accept_cyc[d] + 33 * cdiv(d) + 1);
               check("cs_fall_cycle", cs_fall_cyc[d], accept_cyc[d] + 1);
               check("cs_rise_cycle", cs_rise_cyc[d], cyc);
               check("ready_low_in_frame", ready_in_frame[d], 1'b0);
               check("rsp_single_pulse", prev_rsp[d], 1'b0);
               check("busy_vs_ready", busy[d], !req_ready[d]);
               rsp_cyc[d]       = cyc;
               ready_pending[d] = 1'b1;
            end
         end
         if (!prev_ready[d] && req_ready[d] && ready_pending[d]) begin
            check("ready_return", cyc, rsp_cyc[d] + cdiv(d));
            ready_pending[d] = 1'b0;
         end
         prev_cs[d]    = spi_cs[d];
         prev_clk[d]   = spi_clk[d];
         prev_ready[d] = req_ready[d];
         prev_rsp[d]   = rsp_valid[d];
      end
   end

   task automatic wait_accept(input int d);
      int n = 0;
      @(negedge clk_osc);
      while (!req_ready[d] && n < 1000) begin
         @(negedge clk_osc);
         n++;
      end
      if (!req_ready[d]) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk_osc);
      #1;
   endtask

   task automatic send(input int d, input logic rw, input logic [6:0] addr,
                       input logic [7:0] wdata, input logic [7:0] miso, input logic [7:0] rdata);
      exp_t e;
      e.frame = {rw, addr, rw ? 8'h00 : wdata};
      e.miso  = miso;
      e.rdata = rdata;
      push_exp(d, e);
      @(posedge clk_osc);
      #1;
      req_valid[d] = 1'b1;
      req_rw[d]    = rw;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      wait_accept(d);
      // Disturb the request inputs right after the accept cycle.
      req_valid[d] = 1'b0;
      req_rw[d]    = ~rw;
      req_addr[d]  = ~addr;
      req_wdata[d] = ~wdata;
   endtask

   task automatic wait_done(input int d);
      int n = 0;
      while ((qsize(d) != 0 || !req_ready[d]) && n < 2000) begin
         @(negedge clk_osc);
         n++;
      end
      if (n >= 2000) check("done_timeout", 32'd0, 32'd1);
   endtask

   vec_t vecs[7];
   exp_t e1, e2;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 1'b0, 7'h15, 8'hA5, 8'h5A, 8'h00};
      vecs[1] = '{0, 1'b1, 7'h7F, 8'h33, 8'h3C, 8'h3C};
      vecs[2] = '{0, 1'b0, 7'h00, 8'hFF, 8'h00, 8'h00};
      vecs[3] = '{0, 1'b1, 7'h2A, 8'h00, 8'hC3, 8'hC3};
      vecs[4] = '{1, 1'b1, 7'h01, 8'h00, 8'hFF, 8'hFF};
      vecs[5] = '{1, 1'b1, 7'h02, 8'h00, 8'h00, 8'h00};
      vecs[6] = '{1, 1'b0, 7'h55, 8'h81, 8'hFF, 8'h00};

      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_rw[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
         spi_miso[d] = 1'b0;
         prev_cs[d] = 1'b1; prev_clk[d] = 1'b0; prev_ready[d] = 1'b1; prev_rsp[d] = 1'b0;
         ready_in_frame[d] = 1'b0; ready_pending[d] = 1'b0;
         nrise[d] = 0; resp_idx[d] = 0; cap[d] = '0; resp_frame[d] = '0;
         accept_cyc[d] = 0; cs_fall_cyc[d] = 0; cs_rise_cyc[d] = 0; rise0_cyc[d] = 0;
         rsp_cyc[d] = 0; gap_cyc[d] = 0;
      end

      repeat (3) @(posedge clk_osc);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("reset_cs", spi_cs[d], 1'b1);
         check("reset_sclk", spi_clk[d], 1'b0);
         check("reset_mosi", spi_mosi[d], 1'b0);
         check("reset_ready", req_ready[d], 1'b1);
         check("reset_busy", busy[d], 1'b0);
         check("reset_rsp_valid", rsp_valid[d], 1'b0);
         check("reset_rdata", rsp_rdata[d], 8'h00);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         send(vecs[i].d, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].miso, vecs[i].rdata);
         wait_done(vecs[i].d);
         repeat (3) @(negedge clk_osc);
         check("rdata_hold", rsp_rdata[vecs[i].d], vecs[i].rdata);
      end

      // Held req_valid: write then read, accepted back to back.
      e1.frame = {1'b0, 7'h11, 8'h96}; e1.miso = 8'hFF; e1.rdata = 8'h00;
      e2.frame = {1'b1, 7'h22, 8'h00}; e2.miso = 8'h69; e2.rdata = 8'h69;
      push_exp(0, e1);
      @(posedge clk_osc);
      #1;
      req_valid[0] = 1'b1; req_rw[0] = 1'b0; req_addr[0] = 7'h11; req_wdata[0] = 8'h96;
      wait_accept(0);
      push_exp(0, e2);
      req_rw[0] = 1'b1; req_addr[0] = 7'h22; req_wdata[0] = 8'hEE;
      wait_accept(0);
      req_valid[0] = 1'b0;
      wait_done(0);
      check("b2b_cs_gap", gap_cyc[0], 32'd5);

      // Reset in the middle of a frame.
      send(0, 1'b0, 7'h33, 8'h5A, 8'h00, 8'h00);
      while (cyc != accept_cyc[0] + 50) begin
         @(posedge clk_osc);
         #1;
      end
      check("pre_reset_cs", spi_cs[0], 1'b0);
      rst_n = 1'b0;
      #1;
      check("abort_cs", spi_cs[0], 1'b1);
      check("abort_sclk", spi_clk[0], 1'b0);
      check("abort_mosi", spi_mosi[0], 1'b0);
      check("abort_ready", req_ready[0], 1'b1);
      check("abort_rsp_valid", rsp_valid[0], 1'b0);
      q0.delete();
      repeat (4) @(posedge clk_osc);
      #1;
      rst_n = 1'b1;
      // Any rsp_valid in this window hits an empty scoreboard and is reported.
      repeat (150) @(negedge clk_osc);
      send(0, 1'b1, 7'h4D, 8'h00, 8'hB7, 8'hB7);
      wait_done(0);
      repeat (3) @(negedge clk_osc);
      check("post_reset_rdata", rsp_rdata[0], 8'hB7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
